// File: rtl/cr_isf_ib_arb_pkg.sv
// Shared types and constants for the ISF ingress arbiter and its rotate-priority picker.
package cr_isf_ib_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int CR_ISF_ARB_STALL_W = 16;
    localparam int CR_ISF_ARB_MAX_REQ = 8;

    // Saturating increment for the stall counter; holds at all-ones.
    function automatic logic [CR_ISF_ARB_STALL_W-1:0] stall_sat_inc(
        input logic [CR_ISF_ARB_STALL_W-1:0] v
    );
        return (v == {CR_ISF_ARB_STALL_W{1'b1}}) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cr_isf_ib_arb_rr_pick.sv
// Combinational rotate-priority encoder: finds the first set mask bit searching upward from rr_ptr+1 (mod N).
module cr_isf_rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    elig,
    input  logic [ID_W-1:0] rr_ptr,
    output logic            found,
    output logic [ID_W-1:0] idx
);

    // Walk from the farthest offset to the nearest so the nearest hit wins.
    always_comb begin
        int c;
        c     = 0;
        found = 1'b0;
        idx   = {ID_W{1'b0}};
        for (int off = N; off >= 1; off--) begin
            c     = (int'(rr_ptr) + off) % N;
            idx   = elig[c] ? ID_W'(c) : idx;
            found = found | elig[c];
        end
    end

endmodule

// File: rtl/cr_isf_ib_arb.sv
// Frame-granular round-robin arbiter sharing the ISF ingress AXI4-stream port among N_REQ requesters.
// Optional per-requester frame counters are built when CR_ISF_ARB_STATS_EN is defined.
module cr_isf_ib_arb
    import cr_isf_ib_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 64,
    parameter int USER_W = 8,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_tvalid,
    input  logic [N_REQ-1:0]        req_tlast,
    input  logic [N_REQ*DATA_W-1:0] req_tdata,
    input  logic [N_REQ*USER_W-1:0] req_tuser,
    output logic [N_REQ-1:0]        req_tready,
    output logic                    ib_tvalid,
    output logic                    ib_tlast,
    output logic [DATA_W-1:0]       ib_tdata,
    output logic [USER_W-1:0]       ib_tuser,
    input  logic                    ib_tready,
    input  logic [N_REQ-1:0]        cfg_src_en,
    input  logic [15:0]             cfg_stall_limit,
    output logic [ID_W-1:0]         grant_id,
    output logic                    busy,
    output logic                    stall_evt,
    output logic                    frame_evt
`ifdef CR_ISF_ARB_STATS_EN
    ,
    input  logic                    stat_clr,
    output logic [N_REQ*32-1:0]     stat_frames
`endif
);

    arb_state_e                    state_r;
    logic [ID_W-1:0]               rr_ptr_r;
    logic [ID_W-1:0]               grant_id_r;
    logic [CR_ISF_ARB_STALL_W-1:0] stall_cnt_r;
    logic                          stall_flag_r;
    logic                          stall_evt_r;
    logic                          frame_evt_r;
    logic                          busy_r;

    logic                          pick_found_s;
    logic [ID_W-1:0]               pick_idx_s;
    logic                          gnt_valid_s;
    logic                          eof_s;
    logic [CR_ISF_ARB_STALL_W-1:0] cnt_inc_s;
    logic                          stall_hit_s;

    cr_isf_rr_pick #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_pick (
        .elig   (req_tvalid & cfg_src_en),
        .rr_ptr (rr_ptr_r),
        .found  (pick_found_s),
        .idx    (pick_idx_s)
    );

    assign gnt_valid_s = req_tvalid[grant_id_r];
    assign eof_s       = ib_tvalid & ib_tready & ib_tlast;
    assign cnt_inc_s   = stall_sat_inc(stall_cnt_r);
    assign stall_hit_s = (cfg_stall_limit != 16'd0) && (cnt_inc_s == cfg_stall_limit) && !stall_flag_r;

    // Pass-through of the granted requester; everything quiet while idle.
    always_comb begin
        ib_tvalid  = 1'b0;
        ib_tlast   = 1'b0;
        ib_tdata   = {DATA_W{1'b0}};
        ib_tuser   = {USER_W{1'b0}};
        req_tready = {N_REQ{1'b0}};
        if (state_r == XFER) begin
            ib_tvalid              = gnt_valid_s;
            ib_tlast               = req_tlast[grant_id_r];
            ib_tdata               = req_tdata[int'(grant_id_r)*DATA_W +: DATA_W];
            ib_tuser               = req_tuser[int'(grant_id_r)*USER_W +: USER_W];
            req_tready[grant_id_r] = ib_tready;
        end else begin
            req_tready = {N_REQ{1'b0}};
        end
    end

    // Arbitration FSM with stall tracking and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            rr_ptr_r     <= ID_W'(N_REQ - 1);
            grant_id_r   <= {ID_W{1'b0}};
            stall_cnt_r  <= 16'd0;
            stall_flag_r <= 1'b0;
            stall_evt_r  <= 1'b0;
            frame_evt_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    stall_evt_r  <= 1'b0;
                    frame_evt_r  <= 1'b0;
                    stall_cnt_r  <= 16'd0;
                    stall_flag_r <= 1'b0;
                    if (pick_found_s) begin
                        grant_id_r <= pick_idx_s;
                        state_r    <= XFER;
                        busy_r     <= 1'b1;
                    end
                end
                XFER: begin
                    frame_evt_r <= eof_s;
                    stall_evt_r <= 1'b0;
                    if (eof_s) begin
                        rr_ptr_r     <= grant_id_r;
                        state_r      <= IDLE;
                        busy_r       <= 1'b0;
                        stall_cnt_r  <= 16'd0;
                        stall_flag_r <= 1'b0;
                    end else if (!gnt_valid_s) begin
                        // Only a missing valid counts; backpressure keeps the counter clear.
                        stall_cnt_r <= cnt_inc_s;
                        if (stall_hit_s) begin
                            stall_evt_r  <= 1'b1;
                            stall_flag_r <= 1'b1;
                        end
                    end else begin
                        stall_cnt_r <= 16'd0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id  = grant_id_r;
    assign busy      = busy_r;
    assign stall_evt = stall_evt_r;
    assign frame_evt = frame_evt_r;

`ifdef CR_ISF_ARB_STATS_EN
    logic [31:0] stat_cnt_r [N_REQ];

    // Per-requester accepted-tlast counters; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < N_REQ; i++) begin
                stat_cnt_r[i] <= 32'd0;
            end
        end else if (eof_s) begin
            stat_cnt_r[grant_id_r] <= stat_cnt_r[grant_id_r] + 32'd1;
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
        assign stat_frames[gi*32 +: 32] = stat_cnt_r[gi];
    end
`endif

endmodule

// File: tb/tb_cr_isf_ib_arb.sv
// Randomized self-checking bench for cr_isf_ib_arb against a cycle-level behavioural reference model.
module tb_cr_isf_ib_arb;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int UW = 8;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_tvalid, req_tlast, req_tready, cfg_src_en;
    logic [N*DW-1:0] req_tdata;
    logic [N*UW-1:0] req_tuser;
    logic            ib_tvalid, ib_tlast, ib_tready;
    logic [DW-1:0]   ib_tdata;
    logic [UW-1:0]   ib_tuser;
    logic [15:0]     cfg_stall_limit;
    logic [IW-1:0]   grant_id;
    logic            busy, stall_evt, frame_evt;
`ifdef CR_ISF_ARB_STATS_EN
    logic            stat_clr;
    logic [N*32-1:0] stat_frames;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model: owner is -1 when no requester holds the port.
    int m_owner, m_ptr, m_grant, m_cnt;
    bit m_flag, m_sevt, m_fevt;
    int m_frames [N];
    int n_frames, n_stalls;

    typedef struct {
        int cyc; int pv; int pl; int pr; int en; int lim; int prst; int vmask;
    } phase_t;

    phase_t ph [7] = '{
        '{200, 100, 33, 100, 15,  0, 0, 15},
        '{400,  70, 25,  70, -1,  0, 0, 15},
        '{400,  40, 20,  80, 15,  3, 0, 15},
        '{200, 100, 10,  10, 15,  2, 0, 15},
        '{ 30, 100, 50, 100, 11,  0, 0,  4},
        '{ 60, 100, 30, 100,  4,  4, 0,  4},
        '{500,  60, 25,  60, -1, -1, 3, 15}
    };

    always #5 clk = ~clk;

    cr_isf_ib_arb #(.N_REQ(N), .DATA_W(DW), .USER_W(UW), .ID_W(IW)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_tvalid      (req_tvalid),
        .req_tlast       (req_tlast),
        .req_tdata       (req_tdata),
        .req_tuser       (req_tuser),
        .req_tready      (req_tready),
        .ib_tvalid       (ib_tvalid),
        .ib_tlast        (ib_tlast),
        .ib_tdata        (ib_tdata),
        .ib_tuser        (ib_tuser),
        .ib_tready       (ib_tready),
        .cfg_src_en      (cfg_src_en),
        .cfg_stall_limit (cfg_stall_limit),
        .grant_id        (grant_id),
        .busy            (busy),
        .stall_evt       (stall_evt),
        .frame_evt       (frame_evt)
`ifdef CR_ISF_ARB_STATS_EN
        ,
        .stat_clr        (stat_clr),
        .stat_frames     (stat_frames)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = N - 1;
        m_grant = 0;
        m_cnt   = 0;
        m_flag  = 1'b0;
        m_sevt  = 1'b0;
        m_fevt  = 1'b0;
        for (int i = 0; i < N; i++) m_frames[i] = 0;
    endtask

    task automatic drive(input phase_t p);
        for (int i = 0; i < N; i++) begin
            req_tvalid[i] = ($urandom_range(99) < p.pv) && p.vmask[i];
            req_tlast[i]  = ($urandom_range(99) < p.pl);
            req_tdata[i*DW +: DW] = {$urandom, $urandom};
            req_tuser[i*UW +: UW] = 8'($urandom);
        end
        ib_tready = ($urandom_range(99) < p.pr);
        if (p.en < 0) cfg_src_en = 4'($urandom);
        else          cfg_src_en = 4'(p.en);
        rst = (p.prst > 0) && ($urandom_range(99) < p.prst);
    endtask

    // Compare this cycle's outputs, then advance the model across the coming edge.
    task automatic compare_and_advance();
        int o;
        logic [N-1:0] elig;
        logic v;
        o = m_owner;
        check_eq("busy", busy, 64'(o >= 0));
        check_eq("grant_id", grant_id, 64'(m_grant));
        check_eq("stall_evt", stall_evt, 64'(m_sevt));
        check_eq("frame_evt", frame_evt, 64'(m_fevt));
        n_frames += int'(frame_evt);
        n_stalls += int'(stall_evt);
        if (o >= 0) begin
            check_eq("ib_tvalid", ib_tvalid, 64'(req_tvalid[o]));
            check_eq("ib_tdata", ib_tdata, req_tdata[o*DW +: DW]);
            check_eq("ib_tlast", ib_tlast, 64'(req_tlast[o]));
            check_eq("ib_tuser", ib_tuser, 64'(req_tuser[o*UW +: UW]));
            check_eq("req_tready", 64'(req_tready), 64'(ib_tready) << o);
        end else begin
            check_eq("idle_tvalid", ib_tvalid, 64'd0);
            check_eq("idle_tready", 64'(req_tready), 64'd0);
        end

        m_sevt = 1'b0;
        m_fevt = 1'b0;
        if (rst) begin
            model_reset();
        end else if (o < 0) begin
            elig = req_tvalid & cfg_src_en;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (elig[c]) begin
                    m_owner = c;
                    m_grant = c;
                    break;
                end
            end
            m_cnt  = 0;
            m_flag = 1'b0;
        end else begin
            v = req_tvalid[o];
            if (v && ib_tready && req_tlast[o]) begin
                m_fevt  = 1'b1;
                m_ptr   = o;
                m_owner = -1;
                m_cnt   = 0;
                m_flag  = 1'b0;
                m_frames[o]++;
            end else if (!v) begin
                if (m_cnt < 65535) m_cnt++;
                if (cfg_stall_limit != 16'd0 && m_cnt == int'(cfg_stall_limit) && !m_flag) begin
                    m_sevt = 1'b1;
                    m_flag = 1'b1;
                end
            end else begin
                m_cnt = 0;
            end
        end
    endtask

    initial begin
        rst             = 1'b1;
        req_tvalid      = 4'd0;
        req_tlast       = 4'd0;
        req_tdata       = '0;
        req_tuser       = '0;
        ib_tready       = 1'b0;
        cfg_src_en      = 4'hF;
        cfg_stall_limit = 16'd0;
`ifdef CR_ISF_ARB_STATS_EN
        stat_clr        = 1'b0;
`endif
        n_frames = 0;
        n_stalls = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 64'd0);
        check_eq("rst_grant", grant_id, 64'd0);
        check_eq("rst_tvalid", ib_tvalid, 64'd0);
        check_eq("rst_tready", 64'(req_tready), 64'd0);
        check_eq("rst_evts", {stall_evt, frame_evt}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int p = 0; p < 7; p++) begin
            if (ph[p].lim < 0) cfg_stall_limit = 16'($urandom_range(6, 1));
            else               cfg_stall_limit = 16'(ph[p].lim);
            for (int c = 0; c < ph[p].cyc; c++) begin
                drive(ph[p]);
                @(negedge clk);
                compare_and_advance();
                @(posedge clk);
                #1;
            end
        end

        check_eq("frames_seen", 64'(n_frames > 0), 64'd1);
        check_eq("stalls_seen", 64'(n_stalls > 0), 64'd1);
`ifdef CR_ISF_ARB_STATS_EN
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check_eq("stat_frames", stat_frames[i*32 +: 32], 64'(m_frames[i]));
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
